// File: rtl/timing_recovery_pkg.sv
// Shared defaults and FSM encoding for the symbol-timing recovery loop.
package timing_recovery_pkg;

    localparam int DEF_NB_TED      = 19;
    localparam int DEF_NB_INT      = 24;
    localparam int DEF_NB_CTRL     = 16;
    localparam int DEF_NB_NCO      = 16;
    localparam int DEF_NB_MU       = 8;
    localparam int DEF_NOM_STEP    = 16384;
    localparam int DEF_CTRL_LIM    = 8192;
    localparam int DEF_ACQ_LEN     = 16;
    localparam int DEF_TRACK_DELTA = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

endpackage

// File: rtl/tr_nco.sv
// Phase-accumulator NCO: emits a symbol strobe and the fractional interval on each wrap.
module tr_nco #(
    parameter int NB_NCO  = 16,
    parameter int NB_CTRL = 16,
    parameter int NB_MU   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NB_NCO-1:0]         step,
    input  logic signed [NB_CTRL-1:0] ctrl,
    output logic                      strobe,
    output logic [NB_MU-1:0]          mu
);

    logic [NB_NCO-1:0] acc;
    logic [NB_NCO:0]   inc;
    logic [NB_NCO:0]   sum;

    // The extra top bit of sum is the carry out of the accumulator.
    assign inc = (NB_NCO+1)'(step) + (NB_NCO+1)'(ctrl);
    assign sum = {1'b0, acc} + inc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset here is synchronous like the rest of the codebase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            strobe <= 1'b0;
            mu     <= '0;
        end else begin
            acc    <= sum[NB_NCO-1:0];
            strobe <= sum[NB_NCO];
            if (sum[NB_NCO]) mu <= sum[NB_NCO-1 -: NB_MU];
        end
    end

endmodule

// File: rtl/ted_loop_filter_nco.sv
// PI loop filter with IDLE/ACQ/TRACK gain scheduling, driving the timing NCO.
module ted_loop_filter_nco
    import timing_recovery_pkg::*;
#(
    parameter int NB_TED      = DEF_NB_TED,
    parameter int NB_INT      = DEF_NB_INT,
    parameter int NB_CTRL     = DEF_NB_CTRL,
    parameter int NB_NCO      = DEF_NB_NCO,
    parameter int NB_MU       = DEF_NB_MU,
    parameter int NOM_STEP    = DEF_NOM_STEP,
    parameter int CTRL_LIM    = DEF_CTRL_LIM,
    parameter int ACQ_LEN     = DEF_ACQ_LEN,
    parameter int TRACK_DELTA = DEF_TRACK_DELTA
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_enable,
    input  logic signed [NB_TED-1:0]  i_ted,
    input  logic                      i_ted_valid,
    input  logic [4:0]                i_kp_shift,
    input  logic [4:0]                i_ki_shift,
    output logic signed [NB_CTRL-1:0] o_ctrl,
    output logic                      o_ctrl_valid,
    output logic                      o_strobe,
    output logic [NB_MU-1:0]          o_mu,
    output logic                      o_int_sat,
    output logic                      o_locked
);

    localparam int CNT_W = $clog2(ACQ_LEN + 1);
    localparam logic signed [NB_INT:0]   INT_MAX = (NB_INT+1)'((2 ** (NB_INT - 1)) - 1);
    localparam logic signed [NB_INT+1:0] CTRL_HI = (NB_INT+2)'(CTRL_LIM);

    state_t                    state, state_next;
    logic [CNT_W-1:0]          count;
    logic                      accept;
    logic [5:0]                kp_eff, ki_eff;
    logic signed [NB_TED-1:0]  p_term, i_term;
    logic signed [NB_INT:0]    integ_sum;
    logic signed [NB_INT-1:0]  integ, integ_next;
    logic                      int_clip;
    logic signed [NB_INT+1:0]  ctrl_sum;
    logic signed [NB_CTRL-1:0] ctrl_next;

    assign accept = i_enable && i_ted_valid && (state != IDLE);
    assign o_locked = (state == TRACK);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_enable) state_next = ACQ;
            ACQ:     if (accept && count == CNT_W'(ACQ_LEN - 1)) state_next = TRACK;
            default: state_next = state;
        endcase
        if (!i_enable) state_next = IDLE;
    end

    // Tracking narrows the loop bandwidth; shifts past NB_TED fill with the sign.
    always_comb begin
        kp_eff = 6'(i_kp_shift) + ((state == TRACK) ? 6'(TRACK_DELTA) : 6'd0);
        ki_eff = 6'(i_ki_shift) + ((state == TRACK) ? 6'(TRACK_DELTA) : 6'd0);
        p_term = i_ted >>> kp_eff;
        i_term = i_ted >>> ki_eff;
    end

    always_comb begin
        integ_sum  = (NB_INT+1)'(integ) + (NB_INT+1)'(i_term);
        int_clip   = 1'b0;
        integ_next = NB_INT'(integ_sum);
        if (integ_sum > INT_MAX) begin
            int_clip   = 1'b1;
            integ_next = NB_INT'(INT_MAX);
        end else if (integ_sum < -INT_MAX) begin
            int_clip   = 1'b1;
            integ_next = NB_INT'(-INT_MAX);
        end

        ctrl_sum  = (NB_INT+2)'(p_term) + (NB_INT+2)'(integ_next);
        ctrl_next = NB_CTRL'(ctrl_sum);
        if (ctrl_sum > CTRL_HI)       ctrl_next = NB_CTRL'(CTRL_HI);
        else if (ctrl_sum < -CTRL_HI) ctrl_next = NB_CTRL'(-CTRL_HI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            integ        <= '0;
            count        <= '0;
            o_ctrl       <= '0;
            o_ctrl_valid <= 1'b0;
            o_int_sat    <= 1'b0;
        end else begin
            state        <= state_next;
            o_ctrl_valid <= accept;
            o_int_sat    <= accept && int_clip;
            if (!i_enable) begin
                integ  <= '0;
                o_ctrl <= '0;
                count  <= '0;
            end else if (accept) begin
                integ  <= integ_next;
                o_ctrl <= ctrl_next;
                if (state == ACQ) count <= count + CNT_W'(1);
            end
        end
    end

    // The NCO sees the registered o_ctrl, so a new update steers it one cycle later.
    tr_nco #(
        .NB_NCO  (NB_NCO),
        .NB_CTRL (NB_CTRL),
        .NB_MU   (NB_MU)
    ) u_nco (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (NB_NCO'(NOM_STEP)),
        .ctrl   (o_ctrl),
        .strobe (o_strobe),
        .mu     (o_mu)
    );

endmodule

// File: tb/tb_ted_loop_filter_nco.sv
// Randomized and directed bench for ted_loop_filter_nco against an arithmetic loop model.
module tb_ted_loop_filter_nco;

    localparam int  M_IDLE = 0, M_ACQ = 1, M_TRACK = 2;
    localparam longint IMAX = 8388607;
    localparam longint CLIM = 8192;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic signed [18:0] ted;
    logic               ted_valid;
    logic [4:0]         kp, ki;
    logic signed [15:0] o_ctrl;
    logic               o_ctrl_valid, o_strobe, o_int_sat, o_locked;
    logic [7:0]         o_mu;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    longint m_phase, m_ctrl, m_integ;
    int     m_mode, m_updates, m_mu;
    logic   m_valid, m_strobe, m_sat;

    logic [27:0] act_vec, exp_vec;
    assign act_vec = {o_ctrl, o_ctrl_valid, o_strobe, o_mu, o_int_sat, o_locked};
    assign exp_vec = {16'(m_ctrl), m_valid, m_strobe, 8'(m_mu), m_sat, (m_mode == M_TRACK)};

    always #5 clk = ~clk;

    ted_loop_filter_nco dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (en),
        .i_ted        (ted),
        .i_ted_valid  (ted_valid),
        .i_kp_shift   (kp),
        .i_ki_shift   (ki),
        .o_ctrl       (o_ctrl),
        .o_ctrl_valid (o_ctrl_valid),
        .o_strobe     (o_strobe),
        .o_mu         (o_mu),
        .o_int_sat    (o_int_sat),
        .o_locked     (o_locked)
    );

    // Advance one clock: update the model from the inputs seen at the edge, then settle.
    task automatic step();
        longint nsum, t, pterm, isum, csum;
        int k_p, k_i;
        @(posedge clk);
        if (!rst_n) begin
            m_phase = 0; m_ctrl = 0; m_integ = 0; m_mode = M_IDLE; m_updates = 0;
            m_mu = 0; m_valid = 0; m_strobe = 0; m_sat = 0;
        end else begin
            nsum     = m_phase + 16384 + m_ctrl;
            m_strobe = (nsum >= 65536);
            m_phase  = nsum % 65536;
            if (m_strobe) m_mu = int'(m_phase / 256);
            m_valid = 0;
            m_sat   = 0;
            if (!en) begin
                m_mode = M_IDLE; m_integ = 0; m_ctrl = 0; m_updates = 0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ACQ;
            end else if (ted_valid) begin
                k_p   = int'(kp) + ((m_mode == M_TRACK) ? 2 : 0);
                k_i   = int'(ki) + ((m_mode == M_TRACK) ? 2 : 0);
                t     = ted;
                pterm = t >>> k_p;
                isum  = m_integ + (t >>> k_i);
                if (isum > IMAX) begin isum = IMAX; m_sat = 1; end
                else if (isum < -IMAX) begin isum = -IMAX; m_sat = 1; end
                m_integ = isum;
                csum    = pterm + isum;
                if (csum > CLIM) csum = CLIM;
                else if (csum < -CLIM) csum = -CLIM;
                m_ctrl  = csum;
                m_valid = 1;
                if (m_mode == M_ACQ) begin
                    m_updates++;
                    if (m_updates == 16) m_mode = M_TRACK;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en = 1'($urandom); ted = 19'($urandom); ted_valid = 1'($urandom);
            kp = 5'($urandom); ki = 5'($urandom);
            step();
        end
        n_checks++;
        if (act_vec !== 28'd0) $display("FAIL reset_outputs: got %h expected 0", act_vec);
        else n_pass++;
        en = 1'b0; ted_valid = 1'b0; ted = '0; kp = 5'd2; ki = 5'd6;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_open_loop();
        int strobes = 0;
        en = 1'b1; ted_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            strobes += int'(o_strobe);
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL open_loop cyc%0d: got %h expected %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        n_checks++;
        if (strobes !== 4) $display("FAIL open_loop_strobe_count: got %0d expected 4", strobes);
        else n_pass++;
    endtask

    task automatic restart_loop();
        en = 1'b0; ted_valid = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    task automatic test_acq_gains();
        restart_loop();
        ted = 19'sd1024; kp = 5'd2; ki = 5'd6;
        ted_valid = 1'b1; step();
        n_checks++;
        if (o_ctrl !== 16'sd272 || o_ctrl_valid !== 1'b1)
            $display("FAIL acq_first_update: got ctrl=%0d valid=%b expected ctrl=272 valid=1", o_ctrl, o_ctrl_valid);
        else n_pass++;
        ted_valid = 1'b0; step();
        n_checks++;
        if (o_ctrl !== 16'sd272 || o_ctrl_valid !== 1'b0)
            $display("FAIL acq_hold: got ctrl=%0d valid=%b expected ctrl=272 valid=0", o_ctrl, o_ctrl_valid);
        else n_pass++;
        ted_valid = 1'b1; step();
        n_checks++;
        if (o_ctrl !== 16'sd288) $display("FAIL acq_second_update: got %0d expected 288", o_ctrl);
        else n_pass++;
        ted_valid = 1'b0;
    endtask

    task automatic test_lock();
        restart_loop();
        ted = 19'sd1024; kp = 5'd2; ki = 5'd6; ted_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL lock_update%0d: got %h expected %h", i, act_vec, exp_vec);
            else n_pass++;
            if (i == 15 || i == 16) begin
                n_checks++;
                if (o_locked !== (i == 16)) $display("FAIL lock_flag_update%0d: got %b expected %b", i, o_locked, (i == 16));
                else n_pass++;
            end
            if (i == 16) ted_valid = 1'b1;
        end
        n_checks++;
        if (o_ctrl !== 16'sd324) $display("FAIL track_gain: got %0d expected 324", o_ctrl);
        else n_pass++;
        ted_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int sat_dut = 0, sat_model = 0;
        restart_loop();
        ted = 19'sd262143; kp = 5'd0; ki = 5'd0; ted_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            sat_dut   += int'(o_int_sat);
            sat_model += int'(m_sat);
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL saturation cyc%0d: got %h expected %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        n_checks++;
        if (sat_dut !== sat_model || sat_model == 0)
            $display("FAIL sat_pulse_count: got %0d expected %0d (nonzero)", sat_dut, sat_model);
        else n_pass++;
        n_checks++;
        if (o_ctrl !== 16'sd8192) $display("FAIL ctrl_clamp: got %0d expected 8192", o_ctrl);
        else n_pass++;
        ted_valid = 1'b0;
        // Steady step 24576: strobes should come 2 or 3 cycles apart.
        for (int i = 0; i < 24; i++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL fast_nco cyc%0d: got %h expected %h", i, act_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        restart_loop();
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 39) != 0);
            ted_valid = 1'($urandom);
            ted       = 19'($urandom);
            kp        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            ki        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
            step();
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL random cyc%0d: got %h expected %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        ted_valid = 1'b0; en = 1'b1;
    endtask

    task automatic test_disable_reset();
        bit found = 0;
        restart_loop();
        ted = 19'sd1024; kp = 5'd2; ki = 5'd6; ted_valid = 1'b1;
        for (int i = 0; i < 20; i++) step();
        ted_valid = 1'b0;
        n_checks++;
        if (o_locked !== 1'b1) $display("FAIL pre_disable_lock: got %b expected 1", o_locked);
        else n_pass++;
        en = 1'b0;
        step();
        n_checks++;
        if (o_ctrl !== 16'sd0 || o_locked !== 1'b0)
            $display("FAIL disable_clear: got ctrl=%0d locked=%b expected ctrl=0 locked=0", o_ctrl, o_locked);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (act_vec !== exp_vec) $display("FAIL idle_nco cyc%0d: got %h expected %h", i, act_vec, exp_vec);
            else n_pass++;
        end
        en = 1'b1;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_phase + 16384 + m_ctrl >= 65536) found = 1;
            else step();
        end
        n_checks++;
        if (!found) $display("FAIL wrap_search: got none expected pending wrap within 8 cycles");
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (o_strobe !== 1'b0 || act_vec !== 28'd0)
            $display("FAIL reset_kills_strobe: got %h expected 0", act_vec);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (act_vec !== exp_vec) $display("FAIL post_reset: got %h expected %h", act_vec, exp_vec);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_open_loop();
        test_acq_gains();
        test_lock();
        test_saturation();
        test_random();
        test_disable_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
